alpu_cache: RTL and testbench

- Small fully-associative result cache on the output side of the alpu.
- Accepts tagged results written from the alpu (out/cout) through a valid/ready write port.
- Serves two registered operand-read ports (a, b) back to the issue side, so results are forwarded without a register-file round trip.
- Instantiated inside alpu_with_cache next to the alpu.

---
 rtl/alpu_cache_pkg.sv | 39 +++
 rtl/alpu_cache_match.sv | 23 ++
 rtl/alpu_cache.sv | 175 +++++++++++++++++
 tb/tb_alpu_cache.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alpu_cache_pkg.sv
// Shared types and helpers for the alpu result cache.
// Entry geometry defaults match the alpu's REG_WIDTH and tag width.
package alpu_cache_pkg;

    localparam int ALPU_REG_WIDTH   = 4;
    localparam int ALPU_TAG_WIDTH   = 5;
    localparam int ALPU_NUM_ENTRIES = 4;
    localparam int ALPU_IDX_WIDTH   = $clog2(ALPU_NUM_ENTRIES);

    typedef struct packed {
        logic                      valid;
        logic [ALPU_TAG_WIDTH-1:0] tag;
        logic [ALPU_REG_WIDTH-1:0] data;
        logic                      cout;
    } alpu_cache_entry_t;

    function automatic logic [ALPU_IDX_WIDTH-1:0] onehot_to_idx(
        input logic [ALPU_NUM_ENTRIES-1:0] oh
    );
        logic [ALPU_IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < ALPU_NUM_ENTRIES; i++) begin
            if (oh[i]) idx = idx | ALPU_IDX_WIDTH'(i);
        end
        return idx;
    endfunction

    function automatic logic [ALPU_IDX_WIDTH-1:0] first_free_idx(
        input logic [ALPU_NUM_ENTRIES-1:0] valid
    );
        logic [ALPU_IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = ALPU_NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) idx = ALPU_IDX_WIDTH'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alpu_cache_match.sv
// Combinational tag compare across all cache entries.
// Produces a one-hot hit vector and an any-hit flag.
module alpu_cache_match #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_WIDTH   = 5
) (
    input  logic [NUM_ENTRIES-1:0]                valid_i,
    input  logic [NUM_ENTRIES-1:0][TAG_WIDTH-1:0] tags_i,
    input  logic [TAG_WIDTH-1:0]                  tag_i,
    output logic [NUM_ENTRIES-1:0]                hit_o,
    output logic                                  any_o
);

    always_comb begin
        hit_o = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit_o[i] = valid_i[i] && (tags_i[i] == tag_i);
        end
    end

    assign any_o = |hit_o;

endmodule

// File: rtl/alpu_cache.sv
// Fully-associative result cache beside the alpu: one write port,
// two registered read ports with same-cycle write bypass.
module alpu_cache
    import alpu_cache_pkg::*;
#(
    parameter int REG_WIDTH   = ALPU_REG_WIDTH,
    parameter int TAG_WIDTH   = ALPU_TAG_WIDTH,
    parameter int NUM_ENTRIES = ALPU_NUM_ENTRIES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [TAG_WIDTH-1:0] wr_tag_i,
    input  logic [REG_WIDTH-1:0] wr_data_i,
    input  logic                 wr_cout_i,
    input  logic                 rd_a_valid_i,
    input  logic [TAG_WIDTH-1:0] rd_a_tag_i,
    output logic                 rd_a_hit_o,
    output logic [REG_WIDTH-1:0] rd_a_data_o,
    output logic                 rd_a_cout_o,
    input  logic                 rd_b_valid_i,
    input  logic [TAG_WIDTH-1:0] rd_b_tag_i,
    output logic                 rd_b_hit_o,
    output logic [REG_WIDTH-1:0] rd_b_data_o,
    output logic                 rd_b_cout_o,
    input  logic                 inval_valid_i,
    input  logic [TAG_WIDTH-1:0] inval_tag_i,
    input  logic                 flush_i
);

    localparam int IW = ALPU_IDX_WIDTH;

    alpu_cache_entry_t ent_q [NUM_ENTRIES];
    alpu_cache_entry_t ent_d [NUM_ENTRIES];
    logic [IW-1:0]     victim_q, victim_d;

    logic                 a_hit_q, a_hit_d, a_cout_q, a_cout_d;
    logic                 b_hit_q, b_hit_d, b_cout_q, b_cout_d;
    logic [REG_WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;

    logic [NUM_ENTRIES-1:0]                vld;
    logic [NUM_ENTRIES-1:0][TAG_WIDTH-1:0] tags;
    logic [NUM_ENTRIES-1:0] w_hit, a_hit, b_hit;
    logic                   w_any, a_any, b_any;
    logic                   wr_acc, a_byp, b_byp;
    logic [IW-1:0]          wr_idx;

    always_comb begin
        vld  = '0;
        tags = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            vld[i]  = ent_q[i].valid;
            tags[i] = ent_q[i].tag;
        end
    end

    alpu_cache_match #(.NUM_ENTRIES(NUM_ENTRIES), .TAG_WIDTH(TAG_WIDTH)) u_match_w (
        .valid_i(vld), .tags_i(tags), .tag_i(wr_tag_i),
        .hit_o(w_hit), .any_o(w_any)
    );

    alpu_cache_match #(.NUM_ENTRIES(NUM_ENTRIES), .TAG_WIDTH(TAG_WIDTH)) u_match_a (
        .valid_i(vld), .tags_i(tags), .tag_i(rd_a_tag_i),
        .hit_o(a_hit), .any_o(a_any)
    );

    alpu_cache_match #(.NUM_ENTRIES(NUM_ENTRIES), .TAG_WIDTH(TAG_WIDTH)) u_match_b (
        .valid_i(vld), .tags_i(tags), .tag_i(rd_b_tag_i),
        .hit_o(b_hit), .any_o(b_any)
    );

    assign wr_ready_o = !reset && !flush_i;
    assign wr_acc     = wr_valid_i && wr_ready_o;
    assign a_byp      = wr_acc && (rd_a_tag_i == wr_tag_i);
    assign b_byp      = wr_acc && (rd_b_tag_i == wr_tag_i);

    // Invalidate is applied before the write so a same-tag write wins.
    always_comb begin
        ent_d    = ent_q;
        victim_d = victim_q;
        wr_idx   = '0;
        if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_d[i].valid = 1'b0;
            victim_d = '0;
        end else begin
            if (inval_valid_i) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (vld[i] && tags[i] == inval_tag_i) ent_d[i].valid = 1'b0;
                end
            end
            if (wr_acc) begin
                if (w_any) begin
                    wr_idx = onehot_to_idx(w_hit);
                end else if (!(&vld)) begin
                    wr_idx = first_free_idx(vld);
                end else begin
                    wr_idx   = victim_q;
                    victim_d = victim_q + IW'(1);
                end
                ent_d[wr_idx] = '{1'b1, wr_tag_i, wr_data_i, wr_cout_i};
            end
        end
    end

    always_comb begin
        a_hit_d  = rd_a_valid_i && (a_byp || a_any);
        a_data_d = '0;
        a_cout_d = 1'b0;
        if (rd_a_valid_i && a_byp) begin
            a_data_d = wr_data_i;
            a_cout_d = wr_cout_i;
        end else if (rd_a_valid_i && a_any) begin
            a_data_d = ent_q[onehot_to_idx(a_hit)].data;
            a_cout_d = ent_q[onehot_to_idx(a_hit)].cout;
        end
    end

    always_comb begin
        b_hit_d  = rd_b_valid_i && (b_byp || b_any);
        b_data_d = '0;
        b_cout_d = 1'b0;
        if (rd_b_valid_i && b_byp) begin
            b_data_d = wr_data_i;
            b_cout_d = wr_cout_i;
        end else if (rd_b_valid_i && b_any) begin
            b_data_d = ent_q[onehot_to_idx(b_hit)].data;
            b_cout_d = ent_q[onehot_to_idx(b_hit)].cout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
            victim_q <= '0;
            a_hit_q  <= 1'b0;
            a_data_q <= '0;
            a_cout_q <= 1'b0;
            b_hit_q  <= 1'b0;
            b_data_q <= '0;
            b_cout_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
            victim_q <= victim_d;
            a_hit_q  <= a_hit_d;
            a_data_q <= a_data_d;
            a_cout_q <= a_cout_d;
            b_hit_q  <= b_hit_d;
            b_data_q <= b_data_d;
            b_cout_q <= b_cout_d;
        end
    end

    assign rd_a_hit_o  = a_hit_q;
    assign rd_a_data_o = a_data_q;
    assign rd_a_cout_o = a_cout_q;
    assign rd_b_hit_o  = b_hit_q;
    assign rd_b_data_o = b_data_q;
    assign rd_b_cout_o = b_cout_q;

`ifndef SYNTHESIS
    logic dup_w;
    always_comb begin
        dup_w = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = i + 1; j < NUM_ENTRIES; j++) begin
                if (vld[i] && vld[j] && tags[i] == tags[j]) dup_w = 1'b1;
            end
        end
    end

    a_one_entry_per_tag: assert property (@(posedge clk) disable iff (reset) !dup_w);
`endif

endmodule

// File: tb/tb_alpu_cache.sv
// Randomised bench for alpu_cache against an array-based model
// of the cache rules, plus directed literal checks.
module tb_alpu_cache;

    localparam int RW = 4;
    localparam int TW = 5;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid_i, wr_cout_i, wr_ready_o;
    logic [TW-1:0] wr_tag_i;
    logic [RW-1:0] wr_data_i;
    logic          rd_a_valid_i, rd_a_hit_o, rd_a_cout_o;
    logic [TW-1:0] rd_a_tag_i;
    logic [RW-1:0] rd_a_data_o;
    logic          rd_b_valid_i, rd_b_hit_o, rd_b_cout_o;
    logic [TW-1:0] rd_b_tag_i;
    logic [RW-1:0] rd_b_data_o;
    logic          inval_valid_i, flush_i;
    logic [TW-1:0] inval_tag_i;

    always #5 clk = ~clk;

    alpu_cache #(.REG_WIDTH(RW), .TAG_WIDTH(TW), .NUM_ENTRIES(NE)) dut (
        .clk(clk), .reset(reset),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_tag_i(wr_tag_i), .wr_data_i(wr_data_i), .wr_cout_i(wr_cout_i),
        .rd_a_valid_i(rd_a_valid_i), .rd_a_tag_i(rd_a_tag_i),
        .rd_a_hit_o(rd_a_hit_o), .rd_a_data_o(rd_a_data_o), .rd_a_cout_o(rd_a_cout_o),
        .rd_b_valid_i(rd_b_valid_i), .rd_b_tag_i(rd_b_tag_i),
        .rd_b_hit_o(rd_b_hit_o), .rd_b_data_o(rd_b_data_o), .rd_b_cout_o(rd_b_cout_o),
        .inval_valid_i(inval_valid_i), .inval_tag_i(inval_tag_i),
        .flush_i(flush_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: entry arrays, victim pointer, expected registered read results.
    bit mv [NE];
    int mt [NE];
    int md [NE];
    bit mc [NE];
    int mvict;
    bit e_ah, e_ac, e_bh, e_bc;
    int e_ad, e_bd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mfind(input int t);
        for (int i = 0; i < NE; i++) if (mv[i] && mt[i] == t) return i;
        return -1;
    endfunction

    task automatic mclear();
        for (int i = 0; i < NE; i++) mv[i] = 1'b0;
        mvict = 0;
        e_ah = 0; e_ad = 0; e_ac = 0;
        e_bh = 0; e_bd = 0; e_bc = 0;
    endtask

    task automatic mread(input bit v, input int t, input bit acc,
                         output bit h, output int d, output bit c);
        int i;
        h = 0; d = 0; c = 0;
        if (v) begin
            if (acc && t == int'(wr_tag_i)) begin
                h = 1; d = int'(wr_data_i); c = wr_cout_i;
            end else begin
                i = mfind(t);
                if (i >= 0) begin
                    h = 1; d = md[i]; c = mc[i];
                end
            end
        end
    endtask

    // One clock edge of the model, using the inputs held across the edge.
    task automatic mstep();
        bit acc;
        int iw, fr, ii;
        if (reset) begin
            mclear();
            return;
        end
        acc = wr_valid_i && !flush_i;
        mread(rd_a_valid_i, int'(rd_a_tag_i), acc, e_ah, e_ad, e_ac);
        mread(rd_b_valid_i, int'(rd_b_tag_i), acc, e_bh, e_bd, e_bc);
        if (flush_i) begin
            for (int i = 0; i < NE; i++) mv[i] = 1'b0;
            mvict = 0;
            return;
        end
        iw = mfind(int'(wr_tag_i));
        fr = -1;
        for (int i = 0; i < NE; i++) if (!mv[i] && fr < 0) fr = i;
        if (inval_valid_i) begin
            ii = mfind(int'(inval_tag_i));
            if (ii >= 0) mv[ii] = 1'b0;
        end
        if (acc) begin
            if (iw < 0) begin
                if (fr >= 0) iw = fr;
                else begin
                    iw = mvict;
                    mvict = (mvict + 1) % NE;
                end
            end
            mv[iw] = 1'b1;
            mt[iw] = int'(wr_tag_i);
            md[iw] = int'(wr_data_i);
            mc[iw] = wr_cout_i;
        end
    endtask

    always @(negedge clk) begin
        check("wr_ready", wr_ready_o, !reset && !flush_i);
        check("a_hit", rd_a_hit_o, e_ah);
        check("a_data", rd_a_data_o, e_ad);
        check("a_cout", rd_a_cout_o, e_ac);
        check("b_hit", rd_b_hit_o, e_bh);
        check("b_data", rd_b_data_o, e_bd);
        check("b_cout", rd_b_cout_o, e_bc);
    end

    task automatic cyc();
        @(posedge clk);
        mstep();
        #1;
    endtask

    task automatic set_in(input bit wv, input int wt, input int wd, input bit wc,
                          input bit av, input int at, input bit bv, input int bt,
                          input bit iv, input int it, input bit fl);
        wr_valid_i    = wv;
        wr_tag_i      = TW'(wt);
        wr_data_i     = RW'(wd);
        wr_cout_i     = wc;
        rd_a_valid_i  = av;
        rd_a_tag_i    = TW'(at);
        rd_b_valid_i  = bv;
        rd_b_tag_i    = TW'(bt);
        inval_valid_i = iv;
        inval_tag_i   = TW'(it);
        flush_i       = fl;
    endtask

    task automatic wr(input int t, input int d, input bit c);
        set_in(1, t, d, c, 0, 0, 0, 0, 0, 0, 0);
        cyc();
    endtask

    task automatic rd(input int ta, input int tb);
        set_in(0, 0, 0, 0, 1, ta, 1, tb, 0, 0, 0);
        cyc();
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mclear();
        repeat (3) cyc();
        reset = 1'b0;
        #1 check("ready_after_reset", wr_ready_o, 1);

        set_in(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        cyc();
        check("empty_a_hit", rd_a_hit_o, 0);
        check("empty_a_data", rd_a_data_o, 0);

        wr(3, 'hA, 1);
        set_in(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        cyc();
        check("t3_a_hit", rd_a_hit_o, 1);
        check("t3_a_data", rd_a_data_o, 'hA);
        check("t3_a_cout", rd_a_cout_o, 1);
        set_in(1, 3, 5, 0, 0, 0, 1, 3, 0, 0, 0);
        cyc();
        check("bypass_b_data", rd_b_data_o, 5);
        check("bypass_b_cout", rd_b_cout_o, 0);

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        for (int t = 1; t <= 6; t++) wr(t, t + 8, t[0]);
        rd(1, 5);
        check("evict_t1_miss", rd_a_hit_o, 0);
        check("t5_hit", rd_b_hit_o, 1);
        rd(3, 6);
        check("t3_kept", rd_a_hit_o, 1);
        check("t6_data", rd_b_data_o, 14);
        for (int t = 9; t <= 13; t++) wr(t, t, 0);
        rd(9, 10);
        check("wrap_t9_evicted", rd_a_hit_o, 0);
        check("wrap_t10_kept", rd_b_hit_o, 1);

        wr(7, 'hC, 0);
        set_in(1, 7, 9, 1, 0, 0, 0, 0, 1, 7, 0);
        cyc();
        rd(7, 7);
        check("inval_vs_wr_hit", rd_a_hit_o, 1);
        check("inval_vs_wr_data", rd_a_data_o, 9);
        set_in(0, 0, 0, 0, 1, 7, 0, 0, 1, 7, 0);
        cyc();
        check("inval_same_cycle_read", rd_a_hit_o, 1);
        rd(7, 0);
        check("inval_miss", rd_a_hit_o, 0);

        wr(20, 1, 1);
        set_in(1, 8, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 check("flush_ready_low", wr_ready_o, 0);
        cyc();
        rd(8, 10);
        check("flush_t8_miss", rd_a_hit_o, 0);
        check("flush_t10_miss", rd_b_hit_o, 0);

        for (int n = 0; n < 500; n++) begin
            set_in($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 15),
                   $urandom_range(0, 1), $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 7),
                   $urandom_range(0, 31) == 0);
            cyc();
        end

        wr(3, 6, 1);
        set_in(1, 4, 2, 1, 1, 3, 1, 3, 0, 0, 0);
        cyc();
        #2 reset = 1'b1;
        mclear();
        #1;
        check("async_a_hit", rd_a_hit_o, 0);
        check("async_a_data", rd_a_data_o, 0);
        check("async_b_hit", rd_b_hit_o, 0);
        check("async_ready", wr_ready_o, 0);
        repeat (2) cyc();
        reset = 1'b0;
        rd(3, 4);
        check("post_reset_t3_miss", rd_a_hit_o, 0);
        check("post_reset_t4_miss", rd_b_hit_o, 0);
        rd(1, 2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
